// File: rtl/m_alu_pipe_shifter_if.sv
// Operand/result handshake bundle for m_alu_pipe_shifter; master drives operations, slave is the shifter.
// out_carry/out_zero exist only when ALU_SHIFT_FLAGS_EN is defined.
interface m_alu_pipe_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amount;
  logic [2:0]       in_type;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_type_err;
`ifdef ALU_SHIFT_FLAGS_EN
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amount, in_type, out_ready,
    input  in_ready, out_valid, out_data, out_type_err, out_carry, out_zero
  );
  modport slave (
    input  in_valid, in_data, in_amount, in_type, out_ready,
    output in_ready, out_valid, out_data, out_type_err, out_carry, out_zero
  );
`else
  modport master (
    output in_valid, in_data, in_amount, in_type, out_ready,
    input  in_ready, out_valid, out_data, out_type_err
  );
  modport slave (
    input  in_valid, in_data, in_amount, in_type, out_ready,
    output in_ready, out_valid, out_data, out_type_err
  );
`endif
endinterface

// File: rtl/m_alu_pipe_shifter.sv
// Pipelined barrel shifter (SHL/SHR/ASL/ASR/ROL/ROR, reserved types flagged); ALU_SHIFT_FLAGS_EN adds carry/zero.
// Latency: ceil(log2(WIDTH)/REG_EVERY) cycles from accept to out_valid, one op per cycle.
// Backpressure: single global enable; all ranks hold while out_valid && !out_ready, in_ready mirrors it.
module m_alu_pipe_shifter #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  m_alu_pipe_shifter_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int AW     = LEVELS;

  localparam logic [2:0] T_SHR = 3'd1;
  localparam logic [2:0] T_ASR = 3'd3;
  localparam logic [2:0] T_ROL = 3'd4;
  localparam logic [2:0] T_ROR = 3'd5;

  // Everything an op needs to finish its remaining levels travels with the data.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic [AW-1:0]    amt;
    logic [2:0]       typ;
    logic             sgn;
`ifdef ALU_SHIFT_FLAGS_EN
    logic             shf;
    logic             cy;
    logic             zr;
`endif
  } stage_t;

  stage_t w_stg [LEVELS+1];
  stage_t w_in;
  logic   w_en;
  logic   w_unused;

  assign w_en         = !w_stg[LEVELS].vld || bus.out_ready;
  assign bus.in_ready = w_en;

  always_comb begin
    w_in     = '0;
    w_in.vld = bus.in_valid;
    w_in.dat = bus.in_data;
    w_in.amt = bus.in_amount;
    w_in.typ = bus.in_type;
    w_in.sgn = bus.in_data[WIDTH-1];
  end

  assign w_stg[0] = w_in;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SH       = 1 << l;
    localparam bit HAS_RANK = ((l + 1) % REG_EVERY == 0) || (l == LEVELS - 1);

    stage_t w_cur;
    stage_t w_nxt;

    assign w_cur = w_stg[l];

    always_comb begin
      w_nxt = w_cur;
      // Reserved types (6/7) pass through unshifted.
      if (w_cur.amt[l] && !(&w_cur.typ[2:1])) begin
        case (w_cur.typ)
          T_SHR:   w_nxt.dat = w_cur.dat >> SH;
          T_ASR:   w_nxt.dat = {{SH{w_cur.sgn}}, w_cur.dat[WIDTH-1:SH]};
          T_ROL:   w_nxt.dat = {w_cur.dat[WIDTH-SH-1:0], w_cur.dat[WIDTH-1:WIDTH-SH]};
          T_ROR:   w_nxt.dat = {w_cur.dat[SH-1:0], w_cur.dat[WIDTH-1:SH]};
          default: w_nxt.dat = w_cur.dat << SH;
        endcase
`ifdef ALU_SHIFT_FLAGS_EN
        // The last bit leaving at the highest applied level is the overall carry.
        w_nxt.shf = 1'b1;
        w_nxt.cy  = w_cur.typ[0] ? w_cur.dat[SH-1] : w_cur.dat[WIDTH-SH];
`endif
      end
`ifdef ALU_SHIFT_FLAGS_EN
      if (w_cur.typ == T_ROL) begin
        w_nxt.cy = w_nxt.shf & w_nxt.dat[0];
      end else if (w_cur.typ == T_ROR) begin
        w_nxt.cy = w_nxt.shf & w_nxt.dat[WIDTH-1];
      end
      w_nxt.zr = (w_nxt.dat == '0);
`endif
    end

    if (HAS_RANK) begin : g_rank
      stage_t r_stg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stg <= '0;
        end else if (w_en) begin
          r_stg <= w_nxt;
        end
      end

      assign w_stg[l+1] = r_stg;
    end else begin : g_comb
      assign w_stg[l+1] = w_nxt;
    end
  end

  assign bus.out_valid    = w_stg[LEVELS].vld;
  assign bus.out_data     = w_stg[LEVELS].dat;
  assign bus.out_type_err = &w_stg[LEVELS].typ[2:1];

`ifdef ALU_SHIFT_FLAGS_EN
  assign bus.out_carry = w_stg[LEVELS].cy;
  assign bus.out_zero  = w_stg[LEVELS].zr;
  assign w_unused      = ^{w_stg[LEVELS].amt, w_stg[LEVELS].sgn, w_stg[LEVELS].typ[0],
                           w_stg[LEVELS].shf};
`else
  assign w_unused      = ^{w_stg[LEVELS].amt, w_stg[LEVELS].sgn, w_stg[LEVELS].typ[0]};
`endif

endmodule

// File: tb/tb_m_alu_pipe_shifter.sv
// Randomized and directed bench for m_alu_pipe_shifter against an arithmetic reference model and scoreboard.
// Flag checks are compiled in when ALU_SHIFT_FLAGS_EN is defined.
module tb_m_alu_pipe_shifter;
  localparam int W      = 32;
  localparam int RE     = 2;
  localparam int AW     = $clog2(W);
  localparam int LEVELS = AW;
  localparam int LAT    = (LEVELS + RE - 1) / RE;

  typedef struct {
    logic [W-1:0] dat;
    logic         err;
    logic         cy;
    logic         zr;
    int           cyc;
  } res_t;

  logic clk;
  logic rst_n;

  m_alu_pipe_shifter_if #(.WIDTH(W)) bus ();

  m_alu_pipe_shifter #(.WIDTH(W), .REG_EVERY(RE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_chk;
  int           n_fail;
  int           cyc;
  bit           last_acc;
  bit           chk_lat;
  bit           gap_chk;
  bit           started;
  bit           have_hold;
  logic [W-1:0] hold_dat;
  logic         hold_err;
  res_t         q[$];

  logic [31:0] dir_d [14] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA,
                              32'h80000001, 32'h80000001, 32'h80000000, 32'h12345678,
                              32'h12345678, 32'hF0F0000F, 32'hF0F0000F, 32'hF0F0000F,
                              32'h9ABCDEF0, 32'hAAAAAAAA};
  int          dir_n [14] = '{1, 4, 4, 31, 1, 4, 1, 9, 9, 0, 0, 0, 5, 31};
  logic [2:0]  dir_t [14] = '{3'd0, 3'd3, 3'd1, 3'd3, 3'd5, 3'd4, 3'd0, 3'd6,
                              3'd0, 3'd3, 3'd4, 3'd5, 3'd7, 3'd2};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] d, input int n, input logic [2:0] t);
    res_t r;
    r.err = 1'b0;
    r.cy  = 1'b0;
    r.cyc = 0;
    case (t)
      3'd0, 3'd2: begin
        r.dat = d << n;
        if (n > 0) r.cy = d[W-n];
      end
      3'd1: begin
        r.dat = d >> n;
        if (n > 0) r.cy = d[n-1];
      end
      3'd3: begin
        r.dat = $unsigned($signed(d) >>> n);
        if (n > 0) r.cy = d[n-1];
      end
      3'd4: begin
        r.dat = (n == 0) ? d : ((d << n) | (d >> (W - n)));
        if (n > 0) r.cy = r.dat[0];
      end
      3'd5: begin
        r.dat = (n == 0) ? d : ((d >> n) | (d << (W - n)));
        if (n > 0) r.cy = r.dat[W-1];
      end
      default: begin
        r.dat = d;
        r.err = 1'b1;
      end
    endcase
    r.zr = (r.dat == '0);
    return r;
  endfunction

  // One cycle: sample settled outputs, score transfers, advance to the next falling edge.
  task automatic step();
    res_t e;
    #1;
    last_acc = 1'b0;
    if (have_hold && bus.out_valid) begin
      chk("hold_data", 64'(bus.out_data), 64'(hold_dat));
      chk("hold_err", 64'(bus.out_type_err), 64'(hold_err));
    end
    if (gap_chk && started && q.size() > 0) chk("no_gap", 64'(bus.out_valid), 64'd1);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_result", 64'(bus.out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("data", 64'(bus.out_data), 64'(e.dat));
        chk("type_err", 64'(bus.out_type_err), 64'(e.err));
`ifdef ALU_SHIFT_FLAGS_EN
        chk("carry", 64'(bus.out_carry), 64'(e.cy));
        chk("zero", 64'(bus.out_zero), 64'(e.zr));
`endif
        if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
        started = 1'b1;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e     = model(bus.in_data, int'(bus.in_amount), bus.in_type);
      e.cyc = cyc;
      q.push_back(e);
      last_acc = 1'b1;
    end
    have_hold = bus.out_valid && !bus.out_ready;
    hold_dat  = bus.out_data;
    hold_err  = bus.out_type_err;
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input int n, input logic [2:0] t);
    int tries;
    tries         = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amount = AW'(n);
    bus.in_type   = t;
    do begin
      step();
      tries++;
    end while (!last_acc && tries < 100);
    bus.in_valid = 1'b0;
    chk("accept", 64'(last_acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    last_acc = 0; chk_lat = 0; gap_chk = 0; started = 0; have_hold = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amount = '0; bus.in_type = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_type_err", 64'(bus.out_type_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef ALU_SHIFT_FLAGS_EN
    chk("rst_carry", 64'(bus.out_carry), 64'd0);
    chk("rst_zero", 64'(bus.out_zero), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ops, one at a time, with exact latency.
    bus.out_ready = 1'b1;
    chk_lat       = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(dir_d[i], dir_n[i], dir_t[i]);
      drain();
    end
    chk_lat = 1'b0;

    // Back-to-back stream with a 5-cycle output stall mid-way.
    gap_chk = 1'b1;
    started = 1'b0;
    begin
      int i;
      int s;
      i = 0;
      s = 0;
      while (i < 32 && s < 200) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hAAAAAAAA;
        bus.in_amount = AW'(i);
        bus.in_type   = 3'd0;
        bus.out_ready = !(s >= 12 && s < 17);
        if (s >= 12 && s < 17) begin
          #1;
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        step();
        if (last_acc) i++;
        s++;
      end
      chk("stream_issued", 64'(i), 64'd32);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    gap_chk = 1'b0;

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = ($urandom_range(7) == 0) ? '0 : W'($urandom);
      bus.in_amount = AW'($urandom_range(W - 1));
      bus.in_type   = 3'($urandom_range(7));
      bus.out_ready = ($urandom_range(2) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset with three ops in flight.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = W'($urandom) | 32'h1;
      bus.in_amount = AW'(k + 1);
      bus.in_type   = 3'd0;
      step();
      chk("rst_fill_accept", 64'(last_acc), 64'd1);
    end
    bus.in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
        step();
        n++;
      end
    end
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_data", 64'(bus.out_data), 64'd0);
    q.delete();
    have_hold = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      step();
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    chk_lat = 1'b1;
    send(32'h0000F00D, 3, 3'd0);
    drain();
    chk_lat = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/m_alu_pipe_shifter.md
Name: m_alu_pipe_shifter

Overview:
Parametrised, pipelined successor to the combinational ALU preshifter. It is a log2(WIDTH)-level barrel shifter with configurable pipeline register placement and a valid/ready handshake on both sides. It adds rotate modes and a reserved-type error indication. It sits between the ALU operand stage and the ALU result mux, and is used where a single-cycle 32/64-bit shift breaks timing.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- REG_EVERY, 2, number of mux levels between pipeline register ranks; 1..log2(WIDTH).
- Derived: LEVELS = log2(WIDTH); LAT = ceil(LEVELS/REG_EVERY) (32/2 -> 3); AW = log2(WIDTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_amount  in  AW  shift amount, unsigned, 0..WIDTH-1.
- in_type  in  3  0 SHL, 1 SHR, 2 ASL, 3 ASR, 4 ROL, 5 ROR, 6/7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_type_err  out  1  result came from a reserved in_type.
- out_carry  out  1  last bit shifted out (ALU_SHIFT_FLAGS_EN only).
- out_zero  out  1  out_data == 0 (ALU_SHIFT_FLAGS_EN only).

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all stage valid bits clear immediately.
  - out_valid = 0, out_data = 0, out_type_err = 0, out_carry = 0, out_zero = 0.
  - Stage data registers clear to 0.
- Pipeline structure:
  - Mux level k shifts by 2^k when amount bit k is set, LSB level first.
  - A register rank follows every REG_EVERY levels; the last rank is always the output register.
  - The type, remaining amount bits and original sign/edge bits travel with the data.
- Latency: an operation accepted at edge N presents out_valid = 1 at edge N+LAT, provided there is no stall.
- Flow control:
  - Global enable: en = !out_valid || out_ready; in_ready = en (combinational from out_valid/out_ready only).
  - When en = 0, every rank holds. Bubbles are not collapsed.
  - A transfer occurs on in_valid && in_ready, or on out_valid && out_ready.
  - An accept and a retire in the same cycle is legal; full throughput is 1 op/cycle.
- Arithmetic:
  - SHL/ASL: logical left, zero fill; ASL is identical to SHL.
  - SHR: zero fill. ASR: fill with the original in_data[WIDTH-1].
  - ROL/ROR: circular.
  - Amount 0 returns in_data unchanged for every type.
- Reserved types 6/7: out_data = in_data, out_type_err = 1, carry/zero computed as for amount 0.
- Ordering: results retire strictly in acceptance order; no drop or duplication under any stall pattern.
- Reset mid-operation: all in-flight operations are discarded. After rst_n rises, out_valid stays 0 until a new op has traversed LAT ranks.
- Output stability: out_data and flags stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_SHIFT_FLAGS_EN.
- Defined:
  - out_carry and out_zero are present and registered with out_data.
  - Carry for SHL/ASL (n>0) = in_data[WIDTH-n]; for SHR/ASR = in_data[n-1]; for ROL = out_data[0]; for ROR = out_data[WIDTH-1].
  - Carry = 0 when n = 0.
- Undefined: both ports are absent, the flag logic is removed, and all other behaviour is identical.

Test Plan:
1. WIDTH=32, REG_EVERY=2; SHL 0xAAAAAAAA by 1 -> out_data 0x55555554 exactly 3 cycles after accept; carry 1, zero 0.
2. ASR 0xAAAAAAAA by 4 -> 0xFAAAAAAA; SHR same operand and amount -> 0x0AAAAAAA; ASR by 31 -> 0xFFFFFFFF.
3. ROR 0x80000001 by 1 -> 0xC0000000 (carry 1); ROL 0x80000001 by 4 -> 0x00000018 (carry 0); SHL 0x80000000 by 1 -> 0x00000000 (zero 1, carry 1).
4. Stream SHL 0xAAAAAAAA by amounts 0..31 back-to-back:
   - Drop out_ready for 5 cycles mid-stream.
   - Required: in_ready = 0 throughout the stall.
   - All 32 results equal 0xAAAAAAAA << i, in order, with no gaps once out_ready returns.
5. in_type 6 with in_data 0x12345678 by 9 -> out_data 0x12345678, out_type_err 1; the following valid SHL op has out_type_err 0.
6. Three ops in flight, assert rst_n low between edges:
   - out_valid falls without waiting for a clock edge.
   - After release, no stale result appears.
   - The next op's result arrives at LAT cycles.
